ir_dram_ctl: RTL and testbench

- Parametrised successor to the IR dispatch-RAM path.
- Owns a single-port dispatch RAM holding {parity, A, B, J} words, indexed by an address formed from the IR opcode.
- Captures dispatch fields on LOAD DRAM and checks odd parity.
- Adds a diagnostic load/readback sequencer, so the RAM is writable through 6-bit-style diagnostic chunks instead of being ROM-only.

---
 rtl/ir_dram_ctl.sv | 274 +++++++++++++++++++++++++++
 tb/tb_ir_dram_ctl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_dram_ctl.sv
// ir_dram_ctl -- IR dispatch-RAM controller.
//
// Holds a single-port dispatch RAM of {parity, A[3], B[3], J[J_W]} words.
// On a capture request the RAM address is formed from the IR opcode, the
// word is read and the A/B/J fields, AC and parity status are presented two
// clocks after the capture edge. A diagnostic sequencer stages words through
// CHUNK-wide pieces and writes them into the RAM or reads them back.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ir[12:0]            IR word; ir[12] is IR bit 0 (MSB), ir[0] is IR bit 12
//   load_dram           capture request
//   diag_load           one-cycle diagnostic strobe
//   diag_sel[2:0]       diagnostic function select
//   diag_data[CHUNK]    diagnostic payload chunk
//   dram_a/b/j          captured dispatch fields
//   ac[3:0]             captured IR bits 9..12
//   jrst0               captured opcode 254 with AC = 0
//   par_err             captured word has even parity
//   busy                diagnostic sequencer not idle
//   overrun             sticky: strobe dropped while busy
//   rd_word[SW]         readback word, rd_valid one-cycle pulse with it
module ir_dram_ctl #(
    parameter int J_W       = 8,
    parameter int ADDR_BITS = 9,
    parameter int CHUNK     = 6,
    localparam int SW       = J_W + 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [12:0]      ir,
    input  logic             load_dram,
    input  logic             diag_load,
    input  logic [2:0]       diag_sel,
    input  logic [CHUNK-1:0] diag_data,
    output logic [2:0]       dram_a,
    output logic [2:0]       dram_b,
    output logic [J_W-1:0]   dram_j,
    output logic [3:0]       ac,
    output logic             jrst0,
    output logic             par_err,
    output logic             busy,
    output logic             overrun,
    output logic [SW-1:0]    rd_word,
    output logic             rd_valid
);

    localparam int DATA_W = J_W + 6;
    localparam int DEPTH  = 1 << ADDR_BITS;
    localparam int BANK_W = ADDR_BITS - 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RD1   = 2'd2,
        RD2   = 2'd3
    } state_t;

    state_t                 state_reg;
    logic [DATA_W-1:0]      staging_reg;
    logic [DATA_W-1:0]      staging_shift;
    logic [ADDR_BITS-1:0]   diag_addr_reg;
    logic                   inject_reg;
    logic                   pending_reg;
    logic                   overrun_reg;

    // Capture pipeline: stage 1 holds the IR and RAM address, stage 2 the
    // IR alongside the registered RAM output.
    logic                   cap1_reg;
    logic                   cap2_reg;
    logic [12:0]            ir1_reg;
    logic [12:0]            ir2_reg;
    logic [ADDR_BITS-1:0]   addr1_reg;

    logic [2:0]             dram_a_reg;
    logic [2:0]             dram_b_reg;
    logic [J_W-1:0]         dram_j_reg;
    logic [3:0]             ac_reg;
    logic                   jrst0_reg;
    logic                   par_err_reg;
    logic [SW-1:0]          rd_word_reg;
    logic                   rd_valid_reg;

    logic [8:0]             adr_low;
    logic [ADDR_BITS-1:0]   cap_addr;
    logic                   capture_go;
    logic [ADDR_BITS-1:0]   ram_addr;
    logic                   ram_we;
    logic [SW-1:0]          wr_word;
    logic [SW-1:0]          ram_q;
    logic                   jrst;
    logic [J_W-1:0]         j_next;

    // ------------------------------------------------------------------
    // Dispatch address from the live IR. For 7xx opcodes the middle digit
    // comes from IR[7:9], forced to 7 when IR[3:6] are all ones.
    // ------------------------------------------------------------------
    always_comb begin
        if (ir[12:10] != 3'b111) begin
            adr_low = ir[12:4];
        end else begin
            adr_low = {3'b111, ir[5:3] | {3{&ir[9:6]}}, ir[2:0]};
        end
    end

    generate
        if (BANK_W > 0) begin : g_bank
            logic [BANK_W-1:0] bank_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    bank_reg <= '0;
                end else if (state_reg == IDLE && diag_load && diag_sel == 3'd1) begin
                    bank_reg <= staging_reg[BANK_W-1:0];
                end
            end

            assign cap_addr = {bank_reg, adr_low};
        end else begin : g_nobank
            assign cap_addr = adr_low;
        end
    endgenerate

    // Staging shift register: new chunk enters at the bottom, old bits
    // fall off the top.
    generate
        if (CHUNK >= DATA_W) begin : g_shift_all
            assign staging_shift = diag_data[DATA_W-1:0];
        end else begin : g_shift
            assign staging_shift = {staging_reg[DATA_W-CHUNK-1:0], diag_data};
        end
    endgenerate

    // A diagnostic strobe in IDLE takes precedence over a capture; the
    // capture is then remembered in pending_reg.
    assign capture_go = (state_reg == IDLE) && !diag_load && (load_dram || pending_reg);

    // Odd parity over the whole stored word; inject_reg flips it so an
    // error word can be planted.
    assign wr_word = {(~^staging_reg) ^ inject_reg, staging_reg};

    // Single RAM port. Capture reads never collide with WRITE/RD1 because a
    // capture is only accepted in IDLE without a diagnostic strobe.
    assign ram_we   = (state_reg == WRITE);
    assign ram_addr = (state_reg == WRITE || state_reg == RD1) ? diag_addr_reg : addr1_reg;

    logic [SW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= wr_word;
        end
        ram_q <= mem[ram_addr];
    end

    // JRST substitutes AC into the low four J bits.
    assign jrst = (ir2_reg[12:4] == 9'o254);

    generate
        if (J_W > 4) begin : g_j_wide
            assign j_next = jrst ? {ram_q[J_W-1:4], ir2_reg[3:0]} : ram_q[J_W-1:0];
        end else begin : g_j_narrow
            assign j_next = jrst ? ir2_reg[J_W-1:0] : ram_q[J_W-1:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sequencer, capture pipeline and registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            staging_reg   <= '0;
            diag_addr_reg <= '0;
            inject_reg    <= 1'b0;
            pending_reg   <= 1'b0;
            overrun_reg   <= 1'b0;
            cap1_reg      <= 1'b0;
            cap2_reg      <= 1'b0;
            ir1_reg       <= '0;
            ir2_reg       <= '0;
            addr1_reg     <= '0;
            dram_a_reg    <= '0;
            dram_b_reg    <= '0;
            dram_j_reg    <= '0;
            ac_reg        <= '0;
            jrst0_reg     <= 1'b0;
            par_err_reg   <= 1'b0;
            rd_word_reg   <= '0;
            rd_valid_reg  <= 1'b0;
        end else begin
            // Capture pipeline
            cap1_reg <= capture_go;
            if (capture_go) begin
                ir1_reg   <= ir;
                addr1_reg <= cap_addr;
            end
            cap2_reg <= cap1_reg;
            if (cap1_reg) begin
                ir2_reg <= ir1_reg;
            end
            if (cap2_reg) begin
                dram_a_reg  <= ram_q[DATA_W-1 -: 3];
                dram_b_reg  <= ram_q[J_W+2 : J_W];
                dram_j_reg  <= j_next;
                ac_reg      <= ir2_reg[3:0];
                jrst0_reg   <= jrst && (ir2_reg[3:0] == 4'd0);
                par_err_reg <= ~^ram_q;
            end

            if (capture_go) begin
                pending_reg <= 1'b0;
            end else if (load_dram) begin
                pending_reg <= 1'b1;
            end

            rd_valid_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (diag_load) begin
                        case (diag_sel)
                            3'd0: diag_addr_reg[8:0] <= staging_reg[8:0];
                            3'd2: staging_reg <= staging_shift;
                            3'd3: begin
                                inject_reg <= 1'b0;
                                state_reg  <= WRITE;
                            end
                            3'd6: begin
                                inject_reg <= 1'b1;
                                state_reg  <= WRITE;
                            end
                            3'd4: state_reg <= RD1;
                            3'd5: begin
                                overrun_reg <= 1'b0;
                                staging_reg <= '0;
                            end
                            default: ;  // 1 handled by the bank register, 7 no-op
                        endcase
                    end
                end
                WRITE: begin
                    diag_addr_reg <= diag_addr_reg + ADDR_BITS'(1);
                    state_reg     <= IDLE;
                end
                RD1: begin
                    state_reg <= RD2;
                end
                RD2: begin
                    rd_word_reg  <= ram_q;
                    rd_valid_reg <= 1'b1;
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase

            if (state_reg != IDLE && diag_load) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign dram_a   = dram_a_reg;
    assign dram_b   = dram_b_reg;
    assign dram_j   = dram_j_reg;
    assign ac       = ac_reg;
    assign jrst0    = jrst0_reg;
    assign par_err  = par_err_reg;
    assign busy     = (state_reg != IDLE);
    assign overrun  = overrun_reg;
    assign rd_word  = rd_word_reg;
    assign rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_ir_dram_ctl.sv
// Testbench for ir_dram_ctl: directed scenarios plus randomized writes,
// readbacks and captures, checked against an array-based reference model.
module tb_ir_dram_ctl;

    localparam int J_W       = 8;
    localparam int ADDR_BITS = 9;
    localparam int CHUNK     = 6;
    localparam int DATA_W    = 14;
    localparam int SW        = 15;

    logic             clk;
    logic             rst_n;
    logic [12:0]      ir;
    logic             load_dram;
    logic             diag_load;
    logic [2:0]       diag_sel;
    logic [CHUNK-1:0] diag_data;
    logic [2:0]       dram_a;
    logic [2:0]       dram_b;
    logic [J_W-1:0]   dram_j;
    logic [3:0]       ac;
    logic             jrst0;
    logic             par_err;
    logic             busy;
    logic             overrun;
    logic [SW-1:0]    rd_word;
    logic             rd_valid;

    ir_dram_ctl #(
        .J_W       (J_W),
        .ADDR_BITS (ADDR_BITS),
        .CHUNK     (CHUNK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ir        (ir),
        .load_dram (load_dram),
        .diag_load (diag_load),
        .diag_sel  (diag_sel),
        .diag_data (diag_data),
        .dram_a    (dram_a),
        .dram_b    (dram_b),
        .dram_j    (dram_j),
        .ac        (ac),
        .jrst0     (jrst0),
        .par_err   (par_err),
        .busy      (busy),
        .overrun   (overrun),
        .rd_word   (rd_word),
        .rd_valid  (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [SW-1:0] ref_mem [512];
    bit            ref_ok  [512];
    int            ref_staging = 0;
    int            ref_diag_addr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Dispatch address as described by the addressing rules
    function automatic int ref_addr(input logic [12:0] v);
        int op;
        int mid;
        op = int'(v) >> 4;
        if ((op >> 6) != 7) return op;
        mid = (int'(v) >> 3) & 7;
        if (((int'(v) >> 6) & 15) == 15) mid = 7;
        return (7 << 6) | (mid << 3) | (int'(v) & 7);
    endfunction

    task automatic diag(input int fn, input int d);
        diag_sel  = 3'(fn);
        diag_data = CHUNK'(d);
        diag_load = 1'b1;
        tick();
        diag_load = 1'b0;
        if (fn == 2) ref_staging = ((ref_staging << CHUNK) | (d & 63)) & 16'h3FFF;
        if (fn == 5) ref_staging = 0;
        if (fn == 0) ref_diag_addr = ref_staging & 511;
    endtask

    task automatic stage(input int data);
        diag(2, (data >> 12) & 63);
        diag(2, (data >> 6) & 63);
        diag(2, data & 63);
    endtask

    task automatic set_addr(input int a);
        stage(a);
        diag(0, 0);
    endtask

    task automatic write_cur(input int data, input bit inj);
        int par;
        stage(data);
        diag(inj ? 6 : 3, 0);
        chk("wr_busy", 32'(busy), 32'd1);
        tick();
        chk("wr_idle", 32'(busy), 32'd0);
        par = ($countones(data & 16'h3FFF) % 2 == 0) ? 1 : 0;
        if (inj) par = 1 - par;
        ref_mem[ref_diag_addr] = SW'((par << DATA_W) | (data & 16'h3FFF));
        ref_ok[ref_diag_addr]  = 1'b1;
        $display("write adr=%0o word=0x%0h inj=%0d", ref_diag_addr, ref_mem[ref_diag_addr], inj);
        ref_diag_addr = (ref_diag_addr + 1) % 512;
    endtask

    task automatic write_at(input int a, input int data, input bit inj);
        set_addr(a);
        write_cur(data, inj);
    endtask

    task automatic ensure_written(input logic [12:0] v);
        int a;
        a = ref_addr(v);
        if (!ref_ok[a]) write_at(a, int'($urandom_range(0, 16383)), 1'b0);
    endtask

    task automatic read_at(input int a);
        set_addr(a);
        diag(4, 0);
        chk("rd_busy", 32'(busy), 32'd1);
        chk("rd_early0", 32'(rd_valid), 32'd0);
        tick();
        chk("rd_early1", 32'(rd_valid), 32'd0);
        tick();
        chk("rd_valid", 32'(rd_valid), 32'd1);
        chk("rd_word", 32'(rd_word), 32'(ref_mem[a]));
        $display("read  adr=%0o word=0x%0h", a, rd_word);
        tick();
        chk("rd_pulse", 32'(rd_valid), 32'd0);
    endtask

    task automatic check_outputs(input logic [12:0] v, input string tag);
        logic [SW-1:0] w;
        int ej;
        int ejr;
        int epe;
        w   = ref_mem[ref_addr(v)];
        ej  = int'(w) & 255;
        ejr = 0;
        if ((int'(v) >> 4) == 'o254) begin
            ej  = (ej & 'hF0) | (int'(v) & 15);
            ejr = ((int'(v) & 15) == 0) ? 1 : 0;
        end
        epe = ($countones(w) % 2 == 0) ? 1 : 0;
        chk({tag, "_a"}, 32'(dram_a), 32'((int'(w) >> 11) & 7));
        chk({tag, "_b"}, 32'(dram_b), 32'((int'(w) >> 8) & 7));
        chk({tag, "_j"}, 32'(dram_j), 32'(ej));
        chk({tag, "_ac"}, 32'(ac), 32'(int'(v) & 15));
        chk({tag, "_jrst0"}, 32'(jrst0), 32'(ejr));
        chk({tag, "_par"}, 32'(par_err), 32'(epe));
        $display("capture %s ir=%o adr=%0o a=%0d b=%0d j=0x%0h par_err=%0d",
                 tag, v, ref_addr(v), dram_a, dram_b, dram_j, par_err);
    endtask

    task automatic capture(input logic [12:0] v, input string tag);
        ensure_written(v);
        ir        = v;
        load_dram = 1'b1;
        tick();
        load_dram = 1'b0;
        ir        = 13'($urandom);
        tick();
        tick();
        check_outputs(v, tag);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a"}, 32'(dram_a), 32'd0);
        chk({tag, "_b"}, 32'(dram_b), 32'd0);
        chk({tag, "_j"}, 32'(dram_j), 32'd0);
        chk({tag, "_ac"}, 32'(ac), 32'd0);
        chk({tag, "_jrst0"}, 32'(jrst0), 32'd0);
        chk({tag, "_par"}, 32'(par_err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ovr"}, 32'(overrun), 32'd0);
        chk({tag, "_rdw"}, 32'(rd_word), 32'd0);
        chk({tag, "_rdv"}, 32'(rd_valid), 32'd0);
    endtask

    initial begin
        logic [12:0] v;
        logic [12:0] y;
        logic [12:0] irs [4];
        int a;

        rst_n     = 1'b1;
        ir        = '0;
        load_dram = 1'b0;
        diag_load = 1'b0;
        diag_sel  = '0;
        diag_data = '0;
        #2 rst_n = 1'b0;
        #20;
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        // JRST word at 0o254
        write_at('o254, (2 << 11) | (5 << 8) | 'h3C, 1'b0);
        v = {9'o254, 4'd0};
        capture(v, "jrst");
        chk("jrst_j_lit", 32'(dram_j), 32'h30);
        ir = 13'($urandom);
        tick();
        tick();
        check_outputs(v, "hold");

        // 7xx composition, with and without IR[3:6] all ones
        capture({9'o712, 4'd4}, "op7xx");
        capture({9'o775, 4'd2}, "op7ff");

        // Parity error injection and repair at address 0x10
        write_at('h10, 'h1A5B, 1'b1);
        capture({9'h010, 4'd3}, "inj");
        chk("inj_par_lit", 32'(par_err), 32'd1);
        write_at('h10, 'h1A5B, 1'b0);
        capture({9'h010, 4'd3}, "fix");
        chk("fix_par_lit", 32'(par_err), 32'd0);

        // Diag address wrap 511 -> 0
        set_addr(511);
        write_cur('h2ACE, 1'b0);
        write_cur('h0F0F, 1'b0);
        read_at(511);
        read_at(0);

        // Capture deferred behind a WRITE, ir taken when serviced
        y = {9'o123, 4'd7};
        ensure_written(y);
        set_addr(100);
        stage('h3333);
        diag(3, 0);
        ir        = 13'($urandom);
        load_dram = 1'b1;
        tick();
        ref_mem[100] = SW'((($countones(14'h3333) % 2 == 0) ? 1 : 0) << DATA_W | 'h3333);
        ref_ok[100]  = 1'b1;
        ref_diag_addr = 101;
        load_dram = 1'b0;
        ir        = y;
        chk("defer_idle", 32'(busy), 32'd0);
        tick();
        ir = 13'($urandom);
        tick();
        tick();
        check_outputs(y, "defer");

        // Diagnostic and capture in the same IDLE cycle
        y = {9'o456, 4'd9};
        ensure_written(y);
        ir        = y;
        load_dram = 1'b1;
        diag_sel  = 3'd7;
        diag_load = 1'b1;
        tick();
        diag_load = 1'b0;
        load_dram = 1'b0;
        tick();
        ir = 13'($urandom);
        tick();
        tick();
        check_outputs(y, "simul");

        // Overrun during RD1, cleared by fn5
        set_addr(0);
        diag(4, 0);
        diag(7, 0);
        chk("ovr_set", 32'(overrun), 32'd1);
        tick();
        chk("ovr_rdv", 32'(rd_valid), 32'd1);
        chk("ovr_rdw", 32'(rd_word), 32'(ref_mem[0]));
        diag(5, 0);
        chk("ovr_clr", 32'(overrun), 32'd0);

        // Back-to-back captures
        for (int i = 0; i < 4; i++) begin
            irs[i] = 13'($urandom);
            ensure_written(irs[i]);
        end
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                ir        = irs[k];
                load_dram = 1'b1;
            end else begin
                ir        = 13'($urandom);
                load_dram = 1'b0;
            end
            tick();
            if (k >= 2) check_outputs(irs[k-2], "b2b");
        end
        load_dram = 1'b0;

        // Randomized mix
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 2))
                0: capture(13'($urandom), "rnd");
                1: begin
                    a = int'($urandom_range(0, 511));
                    write_at(a, int'($urandom_range(0, 16383)), 1'($urandom_range(0, 1)));
                    read_at(a);
                end
                default: begin
                    v = 13'($urandom);
                    write_at(ref_addr(v), int'($urandom_range(0, 16383)), 1'($urandom_range(0, 1)));
                    capture(v, "rndw");
                end
            endcase
        end

        // Asynchronous reset mid-readback with overrun set
        capture({9'o777, 4'd15}, "pre_rst");
        read_at(0);
        set_addr(0);
        diag(4, 0);
        diag(7, 0);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_ovr", 32'(overrun), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_zero("arst");
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_rdv", 32'(rd_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
